// File: rtl/alu_addsub_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
// Stage records are sized to MAX_WIDTH so one packed type serves every
// instance width; instances use the low WIDTH bits and leave the rest zero.
package alu_addsub_pkg;

  localparam int unsigned MAX_WIDTH = 128;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  // One pipeline stage: operands still to be resolved travel with the
  // already-resolved low sum slices and the carry out of the last slice.
  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] a_rem;
    logic [MAX_WIDTH-1:0] b_rem;
    logic [MAX_WIDTH-1:0] sum_done;
    logic                 carry;
    logic                 ovf;
    op_e                  op;
  } stage_t;

  // Carry into bit 0: fixed for plain add/sub, external for the chained forms.
  function automatic logic carry_in_sel(input op_e op, input logic cin);
    logic c0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADDC: c0 = cin;
      OP_SUBB: c0 = cin;
      default: c0 = 1'b0;
    endcase
    return c0;
  endfunction

  // Subtraction forms add the one's complement of B.
  function automatic logic invert_b_sel(input op_e op);
    logic inv;
    case (op)
      OP_SUB:  inv = 1'b1;
      OP_SUBB: inv = 1'b1;
      default: inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/alu_pipelined_cla_addsub_cla_slice.sv
// Combinational carry-lookahead slice: full lookahead inside each BLOCK-bit
// group, group carry-outs ripple into the next group.
module cla_slice #(
  parameter int unsigned SW    = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);

  localparam int unsigned NG = SW / BLOCK;

  logic [SW-1:0] g_s;
  logic [SW-1:0] p_s;
  logic [SW:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each bit carry is a sum of generate/propagate products back to the group carry-in.
  always_comb begin
    logic acc_v;
    logic prod_v;
    acc_v  = 1'b0;
    prod_v = 1'b0;
    c_s    = '0;
    c_s[0] = cin;
    for (int grp = 0; grp < NG; grp++) begin
      for (int i = 1; i <= BLOCK; i++) begin
        acc_v = c_s[grp*BLOCK];
        for (int j = 0; j < i; j++) begin
          acc_v = acc_v & p_s[grp*BLOCK+j];
        end
        for (int j = 0; j < i; j++) begin
          prod_v = g_s[grp*BLOCK+j];
          for (int m = j + 1; m < i; m++) begin
            prod_v = prod_v & p_s[grp*BLOCK+m];
          end
          acc_v = acc_v | prod_v;
        end
        c_s[grp*BLOCK+i] = acc_v;
      end
    end
  end

  assign sum   = p_s ^ c_s[SW-1:0];
  assign cout  = c_s[SW];
  assign c_msb = c_s[SW-1];

endmodule

// File: rtl/alu_pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Slice k of the operands is
// resolved in stage k using the carry registered by stage k-1. The whole
// pipe advances together whenever the output is empty or being consumed.
module alu_pipelined_cla_addsub
  import alu_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned BLOCK  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_lt,
  output logic             o_ltu
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic                 advance_s;
  op_e                  op_s;
  logic [MAX_WIDTH-1:0] a_ext_s;
  logic [MAX_WIDTH-1:0] b_ext_s;
  stage_t               in_stage_s;
  stage_t               last_s;
  stage_t               stg_r [STAGES];
  logic                 tail_unused_s;

  assign op_s = op_e'(i_op);

  // Widen operands into the stage format, complementing B for subtraction.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    a_ext_s[WIDTH-1:0] = i_a;
    if (invert_b_sel(op_s)) begin
      b_ext_s[WIDTH-1:0] = ~i_b;
    end else begin
      b_ext_s[WIDTH-1:0] = i_b;
    end
  end

  // Record entering stage 0: nothing resolved yet, carry is the op's c0.
  always_comb begin
    in_stage_s       = '0;
    in_stage_s.valid = i_valid;
    in_stage_s.a_rem = a_ext_s;
    in_stage_s.b_rem = b_ext_s;
    in_stage_s.carry = carry_in_sel(op_s, i_cin);
    in_stage_s.op    = op_s;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        prev_s;
    stage_t        nxt_s;
    logic [SW-1:0] sum_s;
    logic          cout_s;
    logic          c_msb_s;

    if (k == 0) begin : g_head
      assign prev_s = in_stage_s;
    end else begin : g_body
      assign prev_s = stg_r[k-1];
    end

    cla_slice #(
      .SW    (SW),
      .BLOCK (BLOCK)
    ) u_slice (
      .a     (prev_s.a_rem[k*SW +: SW]),
      .b     (prev_s.b_rem[k*SW +: SW]),
      .cin   (prev_s.carry),
      .sum   (sum_s),
      .cout  (cout_s),
      .c_msb (c_msb_s)
    );

    // Fold this stage's slice into the record handed to the next stage.
    always_comb begin
      nxt_s = prev_s;
      nxt_s.sum_done[k*SW +: SW] = sum_s;
      nxt_s.carry = cout_s;
      nxt_s.ovf   = c_msb_s ^ cout_s;
    end

    // Stage register: cleared by reset, frozen while the output is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        stg_r[k] <= '0;
      end else if (advance_s) begin
        stg_r[k] <= nxt_s;
      end else begin
        stg_r[k] <= stg_r[k];
      end
    end
  end

  assign last_s    = stg_r[STAGES-1];
  assign advance_s = ~last_s.valid | i_ready;
  assign o_ready   = advance_s;
  assign o_valid   = last_s.valid;

  // Operand copies and padding in the final record have no consumer past here.
  assign tail_unused_s = ^{last_s.a_rem, last_s.b_rem, last_s.sum_done, last_s.op};

  // Result and flags are shown only for a valid op; otherwise held at zero.
  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    o_zero     = 1'b0;
    o_neg      = 1'b0;
    o_lt       = 1'b0;
    o_ltu      = 1'b0;
    if (last_s.valid) begin
      o_result   = last_s.sum_done[WIDTH-1:0];
      o_carry    = last_s.carry;
      o_overflow = last_s.ovf;
      o_zero     = (last_s.sum_done[WIDTH-1:0] == '0);
      o_neg      = last_s.sum_done[WIDTH-1];
      o_lt       = last_s.sum_done[WIDTH-1] ^ last_s.ovf;
      o_ltu      = ~last_s.carry;
    end else begin
      o_result   = '0;
      o_carry    = 1'b0;
      o_overflow = 1'b0;
      o_zero     = 1'b0;
      o_neg      = 1'b0;
      o_lt       = 1'b0;
      o_ltu      = 1'b0;
    end
  end

endmodule
